// File: rtl/pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_adder_if
//  Purpose  : Operand/result handshake bundle for the segmented pipelined
//             adder. The slave side is the adder, the master side feeds
//             operands and consumes results.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_adder
//  Purpose  : WIDTH-bit adder split into WIDTH/SEG pipeline stages. Stage k
//             adds operand segment k plus the registered carry of stage k-1,
//             so the longest carry chain per stage is SEG bits. Operands ride
//             forward and finished sum segments are delayed so that sum, cout
//             and ovf of one beat leave together. Valid/ready handshake with a
//             single global advance (stall) signal, no skid buffer.
//             WIDTH must be an integer multiple of SEG.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  wire logic    sys_clk,
  input  wire logic    sys_rst,
  pipe_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG;

  // per-stage registers: index k holds the state leaving stage k
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic              ovf_q;
  logic              ovf_d;

  // values entering each stage (bus for stage 0, previous register otherwise)
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  logic [SEG:0]      seg_sum [STAGES];
  logic              advance;

  // The whole pipe moves only when the output slot is free or being drained.
  assign advance = !(v_q[STAGES-1] && !bus.out_ready);

  for (genvar k = 0; k < STAGES; k++) begin : g_tap
    if (k == 0) begin : g_head
      assign a_in[k] = bus.in1;
      assign b_in[k] = bus.in2;
      assign s_in[k] = '0;
      assign c_in[k] = bus.cin;
      assign v_in[k] = bus.in_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end
  end

  // Each stage resolves its own SEG-bit segment and passes everything else on.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                 + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};
      a_d[k]     = a_in[k];
      b_d[k]     = b_in[k];
      s_d[k]     = s_in[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      c_d[k]     = seg_sum[k][SEG];
      v_d[k]     = v_in[k];
    end
    // Overflow is only known once the top segment is summed in the last stage.
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
         && (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  // Valid bits and result-carrying registers: reset, otherwise move on advance.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= s_d[k];
      end
    end
  end

  // Operand carry-forward registers need no reset; they only feed later segments.
  always_ff @(posedge sys_clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire
